// File: rtl/mem_pkg.sv
//------------------------------------------------------------------------------
// Module  : mem_pkg
// Brief   : Shared types and defaults for the RAM port arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

  localparam int V_DEF  = 256;
  localparam int AW_DEF = 14;
  localparam int BE_DEF = 32;

  typedef enum logic {
    CPU_OWN  = 1'b0,
    HOST_OWN = 1'b1
  } own_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    HOST = 2'd2
  } rd_owner_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
//------------------------------------------------------------------------------
// Module  : ram_port_arbiter
// Brief   : Shares a single-port RAM between a zero-latency CPU port and a host port.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ram_port_arbiter
  import mem_pkg::*;
#(
  parameter int V        = V_DEF,
  parameter int AW       = AW_DEF,
  parameter int BE       = BE_DEF,
  parameter int MAX_WAIT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_rden,
  input  logic          cpu_wren,
  input  logic [AW-1:0] cpu_address,
  input  logic [BE-1:0] cpu_byteena,
  input  logic [V-1:0]  cpu_writeData,
  output logic [V-1:0]  cpu_readData,
  output logic          cpu_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic          host_lock,
  input  logic [AW-1:0] host_address,
  input  logic [BE-1:0] host_byteena,
  input  logic [V-1:0]  host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [V-1:0]  host_rdata,
  output logic          host_starve,
  output logic          ram_rden,
  output logic          ram_wren,
  output logic [AW-1:0] ram_address,
  output logic [BE-1:0] ram_byteena,
  output logic [V-1:0]  ram_data,
  input  logic [V-1:0]  ram_q
);

  localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);

  own_state_e   r_state;
  own_state_e   w_state_nxt;
  rd_owner_e    r_rd_owner;
  rd_owner_e    w_rd_owner_nxt;
  logic [7:0]   r_wait_cnt;
  logic [V-1:0] r_host_rdata;
  logic         w_cpu_req;
  logic         w_rvalid;

  assign w_cpu_req = cpu_rden | cpu_wren;

  // Ownership FSM: grant and stall are combinational so the CPU sees no added latency.
  always_comb begin
    w_state_nxt = r_state;
    host_gnt    = 1'b0;
    cpu_stall   = 1'b0;
    case (r_state)
      CPU_OWN: begin
        host_gnt = host_req & ~w_cpu_req;
        if (host_lock && !w_cpu_req) w_state_nxt = HOST_OWN;
      end
      HOST_OWN: begin
        host_gnt  = host_req;
        cpu_stall = w_cpu_req;
        // Hold ownership until an in-flight host read has been returned.
        if (!host_lock && r_rd_owner != HOST) w_state_nxt = CPU_OWN;
      end
      default: w_state_nxt = CPU_OWN;
    endcase
    if (!rst) begin
      host_gnt  = 1'b0;
      cpu_stall = 1'b0;
    end
  end

  always_comb begin
    ram_rden       = 1'b0;
    ram_wren       = 1'b0;
    ram_address    = cpu_address;
    ram_byteena    = cpu_byteena;
    ram_data       = cpu_writeData;
    w_rd_owner_nxt = NONE;
    if (host_gnt) begin
      ram_address = host_address;
      ram_byteena = host_byteena;
      ram_data    = host_wdata;
      ram_wren    = host_we;
      ram_rden    = ~host_we;
      if (!host_we) w_rd_owner_nxt = HOST;
    end else if (rst && r_state == CPU_OWN) begin
      ram_wren = cpu_wren;
      ram_rden = cpu_rden & ~cpu_wren;
      if (cpu_rden && !cpu_wren) w_rd_owner_nxt = CPU;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= CPU_OWN;
      r_rd_owner   <= NONE;
      r_wait_cnt   <= 8'd0;
      r_host_rdata <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_owner <= w_rd_owner_nxt;
      if (host_gnt)      r_wait_cnt <= 8'd0;
      else if (host_req) r_wait_cnt <= sat_inc8(r_wait_cnt);
      if (r_rd_owner == HOST) r_host_rdata <= ram_q;
    end
  end

  // Return data is live in the valid cycle, then held until the next host read.
  assign w_rvalid     = rst & (r_rd_owner == HOST);
  assign host_rvalid  = w_rvalid;
  assign host_rdata   = !rst ? '0 : (w_rvalid ? ram_q : r_host_rdata);
  assign host_starve  = rst & (r_wait_cnt >= c_max_wait);
  assign cpu_readData = ram_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_ram_port_arbiter
// Brief   : Directed self-checking bench for ram_port_arbiter with a small RAM model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_port_arbiter;

  localparam int V  = 256;
  localparam int AW = 14;
  localparam int BE = 32;

  localparam logic [V-1:0]  PAT_A5  = {32{8'hA5}};
  localparam logic [V-1:0]  PAT_5A  = {32{8'h5A}};
  localparam logic [V-1:0]  PAT_LOW = {224'd0, 32'hFFFF_FFFF};
  localparam logic [V-1:0]  ALL_ONE = {V{1'b1}};
  localparam logic [BE-1:0] BE_ALL  = {BE{1'b1}};

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_rden, cpu_wren;
  logic [AW-1:0] cpu_address;
  logic [BE-1:0] cpu_byteena;
  logic [V-1:0]  cpu_writeData, cpu_readData;
  logic          cpu_stall;
  logic          host_req, host_we, host_lock;
  logic [AW-1:0] host_address;
  logic [BE-1:0] host_byteena;
  logic [V-1:0]  host_wdata;
  logic          host_gnt, host_rvalid, host_starve;
  logic [V-1:0]  host_rdata;
  logic          ram_rden, ram_wren;
  logic [AW-1:0] ram_address;
  logic [BE-1:0] ram_byteena;
  logic [V-1:0]  ram_data;
  logic [V-1:0]  ram_q = '0;

  logic [V-1:0]  mem [0:63];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.V(V), .AW(AW), .BE(BE), .MAX_WAIT(64)) dut (
    .clk(clk), .rst(rst),
    .cpu_rden(cpu_rden), .cpu_wren(cpu_wren), .cpu_address(cpu_address),
    .cpu_byteena(cpu_byteena), .cpu_writeData(cpu_writeData),
    .cpu_readData(cpu_readData), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_lock(host_lock),
    .host_address(host_address), .host_byteena(host_byteena),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .host_starve(host_starve),
    .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_address(ram_address),
    .ram_byteena(ram_byteena), .ram_data(ram_data), .ram_q(ram_q)
  );

  // ip_ram stand-in: byte-enabled write, one-cycle registered read.
  always @(posedge clk) begin
    if (ram_wren)
      for (int b = 0; b < BE; b++)
        if (ram_byteena[b]) mem[ram_address[5:0]][8*b +: 8] <= ram_data[8*b +: 8];
    if (ram_rden) ram_q <= mem[ram_address[5:0]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_rden = 0; cpu_wren = 0; cpu_address = '0; cpu_byteena = BE_ALL; cpu_writeData = '0;
    host_req = 0; host_we = 0; host_lock = 0; host_address = '0; host_byteena = BE_ALL;
    host_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 0; cpu_rden = 1; host_req = 1;
    @(negedge clk);
    checks += 7;
    if (ram_rden !== 1'b0) begin failures++; $display("FAIL reset_rden got=%b exp=0", ram_rden); end
    if (ram_wren !== 1'b0) begin failures++; $display("FAIL reset_wren got=%b exp=0", ram_wren); end
    if (host_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", host_gnt); end
    if (cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", cpu_stall); end
    if (host_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", host_rvalid); end
    if (host_rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", host_rdata); end
    if (host_starve !== 1'b0) begin failures++; $display("FAIL reset_starve got=%b exp=0", host_starve); end
    step();
    rst = 1; idle();
    step();
  endtask

  task automatic test_host_write();
    host_req = 1; host_we = 1; host_address = 14'd3; host_wdata = PAT_A5;
    @(negedge clk);
    checks += 6;
    if (host_gnt !== 1'b1) begin failures++; $display("FAIL hw_gnt got=%b exp=1", host_gnt); end
    if (ram_wren !== 1'b1) begin failures++; $display("FAIL hw_wren got=%b exp=1", ram_wren); end
    if (ram_rden !== 1'b0) begin failures++; $display("FAIL hw_rden got=%b exp=0", ram_rden); end
    if (ram_address !== 14'd3) begin failures++; $display("FAIL hw_addr got=%0d exp=3", ram_address); end
    if (ram_byteena !== 32'hFFFF_FFFF) begin failures++; $display("FAIL hw_be got=%h exp=ffffffff", ram_byteena); end
    if (ram_data !== PAT_A5) begin failures++; $display("FAIL hw_data got=%h exp=%h", ram_data, PAT_A5); end
    step();
    host_address = 14'd5; host_wdata = PAT_5A;
    @(negedge clk);
    checks++;
    if (host_gnt !== 1'b1) begin failures++; $display("FAIL hw2_gnt got=%b exp=1", host_gnt); end
    step();
    idle();
    @(negedge clk);
    checks++;
    if (host_rvalid !== 1'b0) begin failures++; $display("FAIL hw_rvalid got=%b exp=0", host_rvalid); end
    step();
  endtask

  task automatic test_cpu_read();
    cpu_rden = 1; cpu_address = 14'd5;
    @(negedge clk);
    checks += 4;
    if (ram_rden !== 1'b1) begin failures++; $display("FAIL cr_rden got=%b exp=1", ram_rden); end
    if (ram_address !== 14'd5) begin failures++; $display("FAIL cr_addr got=%0d exp=5", ram_address); end
    if (cpu_stall !== 1'b0) begin failures++; $display("FAIL cr_stall got=%b exp=0", cpu_stall); end
    if (host_gnt !== 1'b0) begin failures++; $display("FAIL cr_gnt got=%b exp=0", host_gnt); end
    step();
    idle();
    @(negedge clk);
    checks += 2;
    if (cpu_readData !== PAT_5A) begin failures++; $display("FAIL cr_data got=%h exp=%h", cpu_readData, PAT_5A); end
    if (host_rvalid !== 1'b0) begin failures++; $display("FAIL cr_rvalid got=%b exp=0", host_rvalid); end
    step();
  endtask

  task automatic test_cpu_write_priority();
    cpu_rden = 1; cpu_wren = 1; cpu_address = 14'd7; cpu_byteena = 32'h0000_000F;
    cpu_writeData = ALL_ONE;
    host_req = 1; host_we = 0; host_address = 14'd7;
    @(negedge clk);
    checks += 4;
    if (ram_wren !== 1'b1) begin failures++; $display("FAIL cw_wren got=%b exp=1", ram_wren); end
    if (ram_rden !== 1'b0) begin failures++; $display("FAIL cw_rden got=%b exp=0", ram_rden); end
    if (ram_byteena !== 32'h0000_000F) begin failures++; $display("FAIL cw_be got=%h exp=0000000f", ram_byteena); end
    if (host_gnt !== 1'b0) begin failures++; $display("FAIL cw_gnt got=%b exp=0", host_gnt); end
    step();
    cpu_rden = 0; cpu_wren = 0;
    @(negedge clk);
    checks += 2;
    if (host_gnt !== 1'b1) begin failures++; $display("FAIL cw_hgnt got=%b exp=1", host_gnt); end
    if (ram_rden !== 1'b1) begin failures++; $display("FAIL cw_hrden got=%b exp=1", ram_rden); end
    step();
    idle();
    @(negedge clk);
    checks += 2;
    if (host_rvalid !== 1'b1) begin failures++; $display("FAIL cw_rvalid got=%b exp=1", host_rvalid); end
    if (host_rdata !== PAT_LOW) begin failures++; $display("FAIL cw_rdata got=%h exp=%h", host_rdata, PAT_LOW); end
    step();
  endtask

  task automatic test_host_wait();
    host_req = 1; host_we = 0; host_address = 14'd3;
    for (int i = 0; i < 3; i++) begin
      cpu_rden = 1; cpu_address = 14'd5;
      @(negedge clk);
      checks++;
      if (host_gnt !== 1'b0) begin failures++; $display("FAIL wait_gnt%0d got=%b exp=0", i, host_gnt); end
      step();
    end
    cpu_rden = 0;
    @(negedge clk);
    checks += 3;
    if (dut.r_wait_cnt !== 8'd3) begin failures++; $display("FAIL wait_cnt got=%0d exp=3", dut.r_wait_cnt); end
    if (host_gnt !== 1'b1) begin failures++; $display("FAIL wait_gnt4 got=%b exp=1", host_gnt); end
    if (ram_address !== 14'd3) begin failures++; $display("FAIL wait_addr got=%0d exp=3", ram_address); end
    step();
    host_req = 0;
    @(negedge clk);
    checks += 2;
    if (host_rvalid !== 1'b1) begin failures++; $display("FAIL wait_rvalid got=%b exp=1", host_rvalid); end
    if (host_rdata !== PAT_A5) begin failures++; $display("FAIL wait_rdata got=%h exp=%h", host_rdata, PAT_A5); end
    step();
    @(negedge clk);
    checks += 2;
    if (host_rvalid !== 1'b0) begin failures++; $display("FAIL wait_rvalid_end got=%b exp=0", host_rvalid); end
    if (host_rdata !== PAT_A5) begin failures++; $display("FAIL wait_rdata_hold got=%h exp=%h", host_rdata, PAT_A5); end
    step();
  endtask

  task automatic test_lock();
    host_lock = 1; cpu_wren = 1; cpu_writeData = PAT_5A;
    for (int i = 0; i < 2; i++) begin
      cpu_address = 14'(8 + i);
      @(negedge clk);
      checks += 3;
      if (cpu_stall !== 1'b0) begin failures++; $display("FAIL lk_stall%0d got=%b exp=0", i, cpu_stall); end
      if (ram_wren !== 1'b1) begin failures++; $display("FAIL lk_wren%0d got=%b exp=1", i, ram_wren); end
      if (ram_address !== 14'(8 + i)) begin failures++; $display("FAIL lk_addr%0d got=%0d exp=%0d", i, ram_address, 8 + i); end
      step();
    end
    cpu_wren = 0;
    step();
    cpu_rden = 1; cpu_address = 14'd8;
    host_req = 1; host_we = 0; host_address = 14'd7;
    @(negedge clk);
    checks += 4;
    if (cpu_stall !== 1'b1) begin failures++; $display("FAIL lk_stall_on got=%b exp=1", cpu_stall); end
    if (host_gnt !== 1'b1) begin failures++; $display("FAIL lk_gnt got=%b exp=1", host_gnt); end
    if (ram_address !== 14'd7) begin failures++; $display("FAIL lk_haddr got=%0d exp=7", ram_address); end
    if (ram_rden !== 1'b1) begin failures++; $display("FAIL lk_hrden got=%b exp=1", ram_rden); end
    step();
    host_req = 0; host_lock = 0;
    @(negedge clk);
    checks += 4;
    if (cpu_stall !== 1'b1) begin failures++; $display("FAIL lk_stall_rd got=%b exp=1", cpu_stall); end
    if (host_rvalid !== 1'b1) begin failures++; $display("FAIL lk_rvalid got=%b exp=1", host_rvalid); end
    if (host_rdata !== PAT_LOW) begin failures++; $display("FAIL lk_rdata got=%h exp=%h", host_rdata, PAT_LOW); end
    if (ram_rden !== 1'b0) begin failures++; $display("FAIL lk_cpu_blocked got=%b exp=0", ram_rden); end
    step();
    @(negedge clk);
    checks++;
    if (cpu_stall !== 1'b1) begin failures++; $display("FAIL lk_stall_last got=%b exp=1", cpu_stall); end
    step();
    @(negedge clk);
    checks += 3;
    if (cpu_stall !== 1'b0) begin failures++; $display("FAIL lk_stall_off got=%b exp=0", cpu_stall); end
    if (ram_rden !== 1'b1) begin failures++; $display("FAIL lk_cpu_rden got=%b exp=1", ram_rden); end
    if (ram_address !== 14'd8) begin failures++; $display("FAIL lk_cpu_addr got=%0d exp=8", ram_address); end
    step();
    idle();
    @(negedge clk);
    checks++;
    if (cpu_readData !== PAT_5A) begin failures++; $display("FAIL lk_cpu_data got=%h exp=%h", cpu_readData, PAT_5A); end
    step();
  endtask

  task automatic test_back_to_back();
    host_req = 1; host_we = 0; host_address = 14'd3;
    @(negedge clk);
    checks += 2;
    if (host_gnt !== 1'b1) begin failures++; $display("FAIL b2b_gnt got=%b exp=1", host_gnt); end
    if (ram_address !== 14'd3) begin failures++; $display("FAIL b2b_haddr got=%0d exp=3", ram_address); end
    step();
    host_req = 0; cpu_rden = 1; cpu_address = 14'd5;
    @(negedge clk);
    checks += 5;
    if (ram_rden !== 1'b1) begin failures++; $display("FAIL b2b_rden got=%b exp=1", ram_rden); end
    if (ram_address !== 14'd5) begin failures++; $display("FAIL b2b_caddr got=%0d exp=5", ram_address); end
    if (host_rvalid !== 1'b1) begin failures++; $display("FAIL b2b_rvalid got=%b exp=1", host_rvalid); end
    if (host_rdata !== PAT_A5) begin failures++; $display("FAIL b2b_rdata got=%h exp=%h", host_rdata, PAT_A5); end
    if (cpu_readData !== PAT_A5) begin failures++; $display("FAIL b2b_q1 got=%h exp=%h", cpu_readData, PAT_A5); end
    step();
    idle();
    @(negedge clk);
    checks += 2;
    if (host_rvalid !== 1'b0) begin failures++; $display("FAIL b2b_rvalid_end got=%b exp=0", host_rvalid); end
    if (cpu_readData !== PAT_5A) begin failures++; $display("FAIL b2b_cpu_data got=%h exp=%h", cpu_readData, PAT_5A); end
    step();
  endtask

  task automatic test_starve_and_reset();
    host_req = 1; host_we = 0; host_address = 14'd5;
    cpu_rden = 1; cpu_address = 14'd3;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 63) begin
        checks += 2;
        if (host_starve !== 1'b0) begin failures++; $display("FAIL sv_starve63 got=%b exp=0", host_starve); end
        if (dut.r_wait_cnt !== 8'd63) begin failures++; $display("FAIL sv_cnt63 got=%0d exp=63", dut.r_wait_cnt); end
      end
      step();
    end
    @(negedge clk);
    checks += 2;
    if (host_starve !== 1'b1) begin failures++; $display("FAIL sv_starve64 got=%b exp=1", host_starve); end
    if (host_gnt !== 1'b0) begin failures++; $display("FAIL sv_gnt64 got=%b exp=0", host_gnt); end
    step();
    cpu_rden = 0;
    @(negedge clk);
    checks += 2;
    if (host_gnt !== 1'b1) begin failures++; $display("FAIL sv_gnt got=%b exp=1", host_gnt); end
    if (host_starve !== 1'b1) begin failures++; $display("FAIL sv_starve_at_gnt got=%b exp=1", host_starve); end
    step();
    host_req = 0;
    @(negedge clk);
    checks += 2;
    if (host_starve !== 1'b0) begin failures++; $display("FAIL sv_starve_clr got=%b exp=0", host_starve); end
    if (host_rdata !== PAT_5A) begin failures++; $display("FAIL sv_rdata got=%h exp=%h", host_rdata, PAT_5A); end
    step();
    host_req = 1; host_address = 14'd3; host_lock = 1;
    @(negedge clk);
    checks++;
    if (host_gnt !== 1'b1) begin failures++; $display("FAIL rs_gnt got=%b exp=1", host_gnt); end
    step();
    rst = 0;
    @(negedge clk);
    checks += 7;
    if (host_rvalid !== 1'b0) begin failures++; $display("FAIL rs_rvalid got=%b exp=0", host_rvalid); end
    if (host_rdata !== '0) begin failures++; $display("FAIL rs_rdata got=%h exp=0", host_rdata); end
    if (host_gnt !== 1'b0) begin failures++; $display("FAIL rs_gnt_low got=%b exp=0", host_gnt); end
    if (ram_rden !== 1'b0) begin failures++; $display("FAIL rs_rden got=%b exp=0", ram_rden); end
    if (ram_wren !== 1'b0) begin failures++; $display("FAIL rs_wren got=%b exp=0", ram_wren); end
    if (cpu_stall !== 1'b0) begin failures++; $display("FAIL rs_stall got=%b exp=0", cpu_stall); end
    if (host_starve !== 1'b0) begin failures++; $display("FAIL rs_starve got=%b exp=0", host_starve); end
    step();
    rst = 1; host_req = 0; cpu_rden = 1; cpu_address = 14'd5;
    @(negedge clk);
    checks += 3;
    if (host_rvalid !== 1'b0) begin failures++; $display("FAIL rs_rvalid_after got=%b exp=0", host_rvalid); end
    if (cpu_stall !== 1'b0) begin failures++; $display("FAIL rs_lock_released got=%b exp=0", cpu_stall); end
    if (ram_rden !== 1'b1) begin failures++; $display("FAIL rs_cpu_rden got=%b exp=1", ram_rden); end
    step();
    idle();
    step();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst = 0;
    idle();
    step();
    step();
    test_reset();
    test_host_write();
    test_cpu_read();
    test_cpu_write_priority();
    test_host_wait();
    test_lock();
    test_back_to_back();
    test_starve_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
